dark_bus_slave: RTL and testbench

DARK_BUS_SLAVE -- requirements
Module: dark_bus_slave

---
 rtl/dark_bus_slave.sv | 68 ++++++
 tb/tb_dark_bus_slave.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/dark_bus_slave.sv
// dark_bus_slave: bus slave with word RAM, LED/TIMER/ID registers and a 4-state handshake FSM.
module dark_bus_slave #(
    parameter int RAM_AW = 10,
    parameter int LED_W  = 8
) (
    input  logic             clk,
    input  logic             res,
    input  logic             bus_en,
    input  logic             bus_rw,
    input  logic [3:0]       bus_be,
    input  logic [31:0]      bus_addr,
    input  logic [31:0]      bus_wdata,
    output logic [31:0]      bus_rdata,
    output logic             bus_valid,
    output logic             bus_err,
    output logic [LED_W-1:0] led
);
    typedef enum logic [1:0] {IDLE, RD, RESP, GAP} state_t;
    localparam logic [31:0] ID = 32'hDA4C_0001;
    state_t state, state_d;
    logic [31:0] mem [2**RAM_AW];
    logic [31:0] ram_q, timer, rdata_d;
    logic [RAM_AW-1:0] idx;
    logic accept, ram_hit, led_hit, tmr_hit, id_hit, valid_d, err_d, unused;
    assign unused  = ^bus_addr[1:0];
    assign idx     = bus_addr[RAM_AW+1:2];
    assign ram_hit = bus_addr[31:RAM_AW+2] == '0;
    assign led_hit = bus_addr[31:2] == 30'h2000_0000;
    assign tmr_hit = bus_addr[31:2] == 30'h2000_0001;
    assign id_hit  = bus_addr[31:2] == 30'h2000_0002;
    assign accept  = state == IDLE && bus_en;
    always_comb begin
        state_d = state == IDLE ? (accept ? (ram_hit && !bus_rw ? RD : RESP) : IDLE)
                : state == RD   ? RESP
                : state == RESP ? GAP
                : (bus_en ? GAP : IDLE);
        valid_d = state_d == RESP;
        rdata_d = state == RD ? ram_q
                : (accept && !bus_rw) ? (led_hit ? 32'(led) : tmr_hit ? timer : id_hit ? ID : '0)
                : '0;
        err_d   = accept && !(ram_hit || led_hit || tmr_hit || id_hit);
    end
    // RAM is never reset; writes commit at the acceptance edge, reads land in ram_q for the RD cycle
    always_ff @(posedge clk) begin
        if (res && accept && ram_hit) begin
            ram_q <= mem[idx];
            for (int i = 0; i < 4; i++)
                if (bus_rw && bus_be[i]) mem[idx][8*i +: 8] <= bus_wdata[8*i +: 8];
        end
    end
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state     <= IDLE;
            bus_valid <= 1'b0;
            bus_err   <= 1'b0;
            bus_rdata <= '0;
            led       <= '0;
            timer     <= '0;
        end else begin
            state     <= state_d;
            bus_valid <= valid_d;
            bus_err   <= err_d;
            bus_rdata <= rdata_d;
            if (accept && led_hit && bus_rw && bus_be[0]) led <= bus_wdata[LED_W-1:0];
            timer     <= (accept && tmr_hit && bus_rw) ? '0 : timer + 32'd1;
        end
    end
endmodule

// File: tb/tb_dark_bus_slave.sv
// tb_dark_bus_slave: directed vectors with hand-computed expectations for dark_bus_slave.
module tb_dark_bus_slave;
    logic        clk = 1'b0;
    logic        res = 1'b0;
    logic        bus_en = 1'b0, bus_rw = 1'b0;
    logic [3:0]  bus_be = '0;
    logic [31:0] bus_addr = '0, bus_wdata = '0;
    logic [31:0] bus_rdata;
    logic        bus_valid, bus_err;
    logic [7:0]  led;
    int n_chk = 0, n_fail = 0, cyc = 0;
    logic [31:0] rd;
    logic        er;
    int          lat, acc, acc_clr;

    dark_bus_slave #(.RAM_AW(10), .LED_W(8)) dut (
        .clk(clk), .res(res), .bus_en(bus_en), .bus_rw(bus_rw), .bus_be(bus_be),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
        .bus_valid(bus_valid), .bus_err(bus_err), .led(led)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // one transaction; inputs are scrambled after acceptance, bus_en held `hold` extra cycles after valid
    task automatic xfer(input logic rw, input logic [3:0] be, input logic [31:0] a, input logic [31:0] d,
                        input int hold, output logic [31:0] r, output logic e, output int l, output int ac);
        @(negedge clk);
        bus_en = 1'b1; bus_rw = rw; bus_be = be; bus_addr = a; bus_wdata = d;
        l = 0;
        @(posedge clk);
        do begin
            @(negedge clk);
            if (l == 0) ac = cyc;
            l++;
            bus_rw = ~rw; bus_be = ~be; bus_addr = a ^ 32'h4; bus_wdata = ~d;
        end while (!bus_valid && l < 8);
        if (!bus_valid) chk("timeout", 32'(l), 32'd0);
        r = bus_rdata;
        e = bus_err;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("no_second_valid", {31'd0, bus_valid}, 32'd0);
        end
        bus_en = 1'b0;
        @(negedge clk);
        chk("valid_one_cycle", {31'd0, bus_valid}, 32'd0);
        chk("rdata_idle_zero", bus_rdata, 32'd0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_valid", {31'd0, bus_valid}, 32'd0);
        chk("rst_err", {31'd0, bus_err}, 32'd0);
        chk("rst_rdata", bus_rdata, 32'd0);
        chk("rst_led", {24'd0, led}, 32'd0);
        res = 1'b1;

        xfer(1, 4'hF, 32'h10, 32'hDEADBEEF, 0, rd, er, lat, acc);
        chk("wr_lat", 32'(lat), 32'd1);
        chk("wr_err", {31'd0, er}, 32'd0);
        xfer(0, 4'h0, 32'h10, 32'h0, 0, rd, er, lat, acc);
        chk("rd_lat", 32'(lat), 32'd2);
        chk("rd_data", rd, 32'hDEADBEEF);
        chk("rd_err", {31'd0, er}, 32'd0);
        xfer(0, 4'h0, 32'h13, 32'h0, 0, rd, er, lat, acc);
        chk("rd_lowbits", rd, 32'hDEADBEEF);

        xfer(1, 4'h1, 32'h10, 32'h0000_00AA, 0, rd, er, lat, acc);
        xfer(0, 4'h0, 32'h10, 32'h0, 0, rd, er, lat, acc);
        chk("rd_byte0", rd, 32'hDEADBEAA);
        xfer(1, 4'h0, 32'h10, 32'hFFFF_FFFF, 0, rd, er, lat, acc);
        chk("be0_err", {31'd0, er}, 32'd0);
        xfer(0, 4'h0, 32'h10, 32'h0, 0, rd, er, lat, acc);
        chk("rd_be0", rd, 32'hDEADBEAA);

        xfer(1, 4'hF, 32'hFFC, 32'h1234_5678, 0, rd, er, lat, acc);
        xfer(0, 4'h0, 32'hFFC, 32'h0, 0, rd, er, lat, acc);
        chk("rd_top", rd, 32'h1234_5678);
        xfer(0, 4'h0, 32'h1000, 32'h0, 0, rd, er, lat, acc);
        chk("past_ram_lat", 32'(lat), 32'd1);
        chk("past_ram_err", {31'd0, er}, 32'd1);

        xfer(1, 4'h1, 32'h8000_0000, 32'h0000_005A, 0, rd, er, lat, acc);
        chk("led_wr", {24'd0, led}, 32'h5A);
        xfer(1, 4'h2, 32'h8000_0000, 32'h0000_00FF, 0, rd, er, lat, acc);
        chk("led_be", {24'd0, led}, 32'h5A);
        xfer(0, 4'h0, 32'h8000_0000, 32'h0, 0, rd, er, lat, acc);
        chk("led_rd", rd, 32'h0000_005A);
        chk("led_lat", 32'(lat), 32'd1);

        xfer(1, 4'hF, 32'h8000_0008, 32'h0, 0, rd, er, lat, acc);
        chk("id_wr_err", {31'd0, er}, 32'd0);
        xfer(0, 4'h0, 32'h8000_0008, 32'h0, 0, rd, er, lat, acc);
        chk("id_rd", rd, 32'hDA4C_0001);

        xfer(1, 4'h0, 32'h8000_0004, 32'h0, 0, rd, er, lat, acc_clr);
        repeat (5) @(negedge clk);
        xfer(0, 4'h0, 32'h8000_0004, 32'h0, 0, rd, er, lat, acc);
        chk("timer", rd, 32'(acc - acc_clr - 1));

        xfer(0, 4'h0, 32'h4000_0000, 32'h0, 3, rd, er, lat, acc);
        chk("unm_lat", 32'(lat), 32'd1);
        chk("unm_err", {31'd0, er}, 32'd1);
        chk("unm_rdata", rd, 32'd0);
        xfer(1, 4'hF, 32'h8000_0010, 32'hFFFF_FFFF, 0, rd, er, lat, acc);
        chk("unm_wr_err", {31'd0, er}, 32'd1);
        chk("unm_wr_led", {24'd0, led}, 32'h5A);

        @(negedge clk);
        bus_en = 1'b1; bus_rw = 1'b0; bus_be = 4'h0; bus_addr = 32'h10;
        @(negedge clk);
        res = 1'b0;
        bus_en = 1'b0;
        #1;
        chk("rst_mid_led", {24'd0, led}, 32'd0);
        chk("rst_mid_valid", {31'd0, bus_valid}, 32'd0);
        repeat (3) begin
            @(negedge clk);
            chk("rst_mid_novalid", {31'd0, bus_valid}, 32'd0);
        end
        res = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("post_rst_novalid", {31'd0, bus_valid}, 32'd0);
        end
        xfer(0, 4'h0, 32'h10, 32'h0, 0, rd, er, lat, acc);
        chk("post_rst_rd", rd, 32'hDEADBEAA);
        chk("post_rst_lat", 32'(lat), 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
